fetch_queue_unit: RTL and testbench

Parametrised successor to the single-entry fetch stage. It keeps up to QUEUE_DEPTH instruction requests in flight to an in-order instruction memory and buffers the returned words in a FIFO. Decode consumes instructions through a valid/ready handshake. Execute redirects the PC with a single registered pulse that flushes the queue and discards stale responses. Sits between the core's i-mem interface and the decode stage.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/fetch_queue_unit.sv | 140 ++++++++++++++
 tb/tb_fetch_queue_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue unit: FSM states, PC/instruction words and the NOP encoding.
package fetch_pkg;

  localparam int FETCH_DATA_WIDTH   = 32;
  localparam int FETCH_ADDRESS_BITS = 20;

  typedef enum logic {
    FETCH_IDLE,
    FETCH_RUN
  } fetch_state_e;

  typedef logic [FETCH_ADDRESS_BITS-1:0] pc_t;
  typedef logic [FETCH_DATA_WIDTH-1:0]   inst_t;

  localparam inst_t NOP = 32'h00000013;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two FIFO with synchronous flush; head is read straight from storage registers.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never seen.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

  push_into_full: assert property (@(posedge clock) disable iff (reset || flush)
    !(push && count == FULL))
    else $error("fetch_fifo: push into full FIFO");

endmodule

// File: rtl/fetch_queue_unit.sv
// Multi-entry instruction fetch queue with credit-limited issue and redirect flush.
// Optional FETCH_STATS_EN adds issue/drop/redirect/stall counters to the report output.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH   = FETCH_DATA_WIDTH,
  parameter int ADDRESS_BITS = FETCH_ADDRESS_BITS,
  parameter int QUEUE_DEPTH  = 4,
  parameter int CORE         = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDRESS_BITS-1:0] program_address,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_target,
  output logic                    mem_req_valid,
  output logic [ADDRESS_BITS-1:0] mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_instruction,
  output logic [ADDRESS_BITS-1:0] out_PC,
  input  logic                    out_ready,
  input  logic                    report
);

  localparam int          CW        = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(QUEUE_DEPTH);

  fetch_state_e            state_q, state_d;
  logic [ADDRESS_BITS-1:0] pc_q, pc_d;
  logic [CW-1:0]           drop_q, drop_d;
  logic [CW-1:0]           occupancy, outstanding;
  logic [CW:0]             credit_used;
  logic                    run, flush, req_fire, resp_accept, pop;
  logic [ADDRESS_BITS-1:0] aligned_target, tag_head, head_pc;
  logic [DATA_WIDTH-1:0]   head_inst;

  assign run            = (state_q == FETCH_RUN);
  assign flush          = start | (run & redirect_valid);
  assign aligned_target = redirect_target & ~ADDRESS_BITS'(3);
  assign credit_used    = {1'b0, occupancy} + {1'b0, outstanding};

  // Dropped responses do not hold credit: they were already written off at the flush.
  assign mem_req_valid  = run & ~flush & (credit_used < DEPTH_LIM);
  assign mem_req_addr   = pc_q >> 2;
  assign req_fire       = mem_req_valid & mem_req_ready;
  assign resp_accept    = mem_resp_valid & (drop_q == '0) & ~flush;
  assign pop            = out_valid & out_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    if (start) begin
      state_d = FETCH_RUN;
      pc_d    = program_address;
    end else if (flush) begin
      pc_d = aligned_target;
    end else if (req_fire) begin
      pc_d = pc_q + ADDRESS_BITS'(4);
    end
    // A response arriving in the flush cycle is one of the in-flight ones, hence the subtraction.
    if (flush)
      drop_d = drop_q + outstanding - CW'(mem_resp_valid);
    else if (mem_resp_valid && drop_q != '0)
      drop_d = drop_q - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH_IDLE;
      pc_q    <= program_address;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(ADDRESS_BITS)) u_tag_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (resp_accept),
    .head      (tag_head),
    .count     (outstanding)
  );

  fetch_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(ADDRESS_BITS + DATA_WIDTH)) u_data_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (resp_accept),
    .push_data ({tag_head, mem_resp_data}),
    .pop       (pop),
    .head      ({head_pc, head_inst}),
    .count     (occupancy)
  );

  assign out_valid       = (occupancy != '0);
  assign out_instruction = out_valid ? head_inst : '0;
  assign out_PC          = out_valid ? head_pc   : '0;

`ifdef FETCH_STATS_EN
  logic [31:0] stat_issued, stat_dropped, stat_redirects, stat_stalls;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_issued    <= '0;
      stat_dropped   <= '0;
      stat_redirects <= '0;
      stat_stalls    <= '0;
    end else begin
      if (req_fire)                      stat_issued    <= stat_issued + 32'd1;
      if (mem_resp_valid && !resp_accept) stat_dropped  <= stat_dropped + 32'd1;
      if (run && redirect_valid)         stat_redirects <= stat_redirects + 32'd1;
      if (out_valid && !out_ready)       stat_stalls    <= stat_stalls + 32'd1;
    end
  end
`endif

  always @(posedge clock) begin
    if (!reset && report) begin
      $info("core %0d fetch: state=%s pc=%h occ=%0d outstanding=%0d drop=%0d",
            CORE, state_q.name(), pc_q, occupancy, outstanding, drop_q);
`ifdef FETCH_STATS_EN
      $info("core %0d fetch stats: issued=%0d dropped=%0d redirects=%0d stalls=%0d",
            CORE, stat_issued, stat_dropped, stat_redirects, stat_stalls);
`endif
    end
  end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: in-order memory model with variable latency.
module tb_fetch_queue_unit;
  import fetch_pkg::*;

  logic  clock = 1'b0;
  logic  reset, start, redirect_valid, mem_req_valid, mem_req_ready;
  logic  mem_resp_valid, out_valid, out_ready, report;
  pc_t   program_address, redirect_target, mem_req_addr, out_PC;
  inst_t mem_resp_data, out_instruction;

  always #5 clock = ~clock;

  fetch_queue_unit #(.DATA_WIDTH(32), .ADDRESS_BITS(20), .QUEUE_DEPTH(4), .CORE(0)) dut (
    .clock(clock), .reset(reset), .start(start), .program_address(program_address),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_instruction(out_instruction), .out_PC(out_PC),
    .out_ready(out_ready), .report(report)
  );

  typedef struct {
    logic [17:0] addr;
    int          due;
  } req_t;

  req_t pend[$];
  pc_t  exp_q[$];
  pc_t  exp_req_pc, first_pc;
  int   total, bad, cyc, lat, issued, pops, p0;
  bit   watch_first, saw_zero, found;

  function automatic inst_t inst_of(pc_t pc);
    return {12'hC3A, pc};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // One clock cycle: drive memory response, score this cycle's handshakes, advance.
  task automatic tick();
    pc_t e;
    if (reset || pend.size() == 0 || pend[0].due > cyc) begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end else begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = inst_of({pend[0].addr, 2'b00});
      void'(pend.pop_front());
    end
    #1;
    if (reset) begin
      pend.delete();
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("pop_has_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("out_pc", out_PC, e);
          check("out_inst", out_instruction, inst_of(e));
          pops++;
          if (watch_first) begin
            first_pc    = out_PC;
            watch_first = 1'b0;
          end
        end
      end
      if (start || redirect_valid) begin
        check("flush_no_req", mem_req_valid, 1'b0);
        exp_q.delete();
        exp_req_pc  = start ? program_address : (redirect_target & ~20'h3);
        watch_first = 1'b1;
      end else if (mem_req_valid && mem_req_ready) begin
        check("req_addr", mem_req_addr, exp_req_pc >> 2);
        if (mem_req_addr == '0) saw_zero = 1'b1;
        pend.push_back('{addr: mem_req_addr[17:0], due: cyc + lat});
        exp_q.push_back(exp_req_pc);
        exp_req_pc = exp_req_pc + 20'd4;
        issued++;
      end
    end
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_start(input pc_t addr);
    program_address = addr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; lat = 1; issued = 0; pops = 0;
    first_pc = '1; watch_first = 1'b0; saw_zero = 1'b0; exp_req_pc = '0;
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    program_address = 20'h100; mem_req_ready = 1'b1; out_ready = 1'b1; report = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    @(negedge clock);

    // Reset values and idle behaviour.
    repeat (3) tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_out_inst", out_instruction, 32'h0);
    check("rst_out_pc", out_PC, 20'h0);
    reset = 1'b0;
    repeat (2) tick();
    check("idle_no_req", mem_req_valid, 1'b0);

    // Streaming from 0x100 at one instruction per cycle after fill.
    do_start(20'h100);
    repeat (2) tick();
    p0 = pops;
    repeat (12) tick();
    check("stream_rate", pops - p0, 12);

    // Decode stalled: credit limit caps issue at QUEUE_DEPTH.
    out_ready = 1'b0;
    issued = 0;
    do_start(20'h100);
    repeat (6) tick();
    check("hold_inst_mid", out_instruction, inst_of(20'h100));
    repeat (6) tick();
    check("hold_issued", issued, 4);
    check("hold_req_valid", mem_req_valid, 1'b0);
    check("hold_out_valid", out_valid, 1'b1);
    check("hold_out_pc", out_PC, 20'h100);
    check("hold_inst_end", out_instruction, inst_of(20'h100));
    out_ready = 1'b1;
    repeat (10) tick();

    // Redirect with three requests in flight, decode stalled.
    lat = 3;
    out_ready = 1'b0;
    do_start(20'h100);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pend.size() == 3) begin found = 1'b1; break; end
      tick();
    end
    check("redir_3_inflight", found, 1'b1);
    redirect_target = 20'h2000;
    redirect_valid  = 1'b1;
    first_pc = '1;
    tick();
    redirect_valid = 1'b0;
    check("redir_out_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    repeat (25) tick();
    check("redir_first_pc", first_pc, 20'h2000);

    // Redirect coinciding with a response, misaligned target.
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin found = 1'b1; break; end
      tick();
    end
    check("same_cycle_found", found, 1'b1);
    redirect_target = 20'h3003;
    redirect_valid  = 1'b1;
    first_pc = '1;
    tick();
    redirect_valid = 1'b0;
    check("same_cycle_out_valid", out_valid, 1'b0);
    repeat (10) tick();
    check("misalign_first_pc", first_pc, 20'h3000);

    // Random request backpressure and decode stalls, 3-cycle memory.
    lat = 3;
    do_start(20'h400);
    p0 = pops;
    for (int i = 0; i < 4000 && (pops - p0) < 200; i++) begin
      mem_req_ready = 1'($urandom_range(0, 1));
      out_ready     = ($urandom_range(0, 3) != 0);
      tick();
      check("inflight_le_depth", exp_q.size() <= 4, 1'b1);
    end
    check("rand_count", pops - p0, 200);
    mem_req_ready = 1'b1;
    out_ready = 1'b1;

    // PC wrap at the top of the 20-bit address space.
    lat = 1;
    saw_zero = 1'b0;
    do_start(20'hFFFF8);
    repeat (8) tick();
    check("wrap_req_zero", saw_zero, 1'b1);

    // Reset mid-stream, then restart.
    program_address = 20'h500;
    reset = 1'b1;
    repeat (2) tick();
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_req_valid", mem_req_valid, 1'b0);
    reset = 1'b0;
    tick();
    check("midrst_idle", mem_req_valid, 1'b0);
    do_start(20'h500);
    p0 = pops;
    repeat (10) tick();
    check("post_reset_pops", pops - p0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
